uio_bus_arbiter: RTL

//  Round-robin arbiter sharing the 8-bit bidirectional uio pad bus (uio_out/uio_oe) among N_REQ internal

---
 rtl/uio_arb_pkg.sv | 20 ++
 rtl/uio_rr_pick.sv | 23 ++
 rtl/uio_bus_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uio_arb_pkg.sv
// Shared types and width helpers for the uio pad-bus arbiter.
package uio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 8;
  localparam int TURN_DEF  = 1;
  localparam int HOLD_DEF  = 16;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uio_rr_pick.sv
// Combinational rotating-priority picker: search starts just after last_owner and wraps.
module uio_rr_pick
  import uio_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IW    = cnt_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_owner,
  output logic             valid,
  output logic [IW-1:0]    winner
);

  // Walk from farthest to nearest so the nearest requester after last_owner wins.
  always_comb begin
    valid  = |req;
    winner = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (req[(int'(last_owner) + i) % N_REQ]) winner = IW'((int'(last_owner) + i) % N_REQ);
    end
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the shared uio pad bus with a forced all-enables-low turnaround.
// Define UIO_ARB_PREEMPT_EN to revoke a grant held MAX_HOLD cycles while others wait.
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int W           = W_DEF,
  parameter int TURN_CYCLES = TURN_DEF,
  parameter int MAX_HOLD    = HOLD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] wdata,
  input  logic [N_REQ*W-1:0] woe,
  output logic [N_REQ-1:0]   gnt,
  output logic [W-1:0]       uio_out,
  output logic [W-1:0]       uio_oe,
  output logic               busy
);

  localparam int IW = cnt_w(N_REQ);
  localparam int TW = cnt_w(TURN_CYCLES);

  if (N_REQ < 2 || N_REQ > 8 || TURN_CYCLES < 1 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("uio_bus_arbiter: unsupported parameter set");
  end

  logic [N_REQ-1:0][W-1:0] wdata_a, woe_a;
  assign wdata_a = wdata;
  assign woe_a   = woe;

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [TW-1:0]    turn_q, turn_d;
  logic             pick_valid, take;
  logic [IW-1:0]    pick_idx;

`ifdef UIO_ARB_PREEMPT_EN
  localparam int HW = cnt_w(MAX_HOLD + 1);
  logic [HW-1:0] hold_q, hold_d;
  logic          preempt;
`endif

  uio_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req        (req),
    .last_owner (owner_q),
    .valid      (pick_valid),
    .winner     (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    turn_d  = turn_q;
    take    = 1'b0;
`ifdef UIO_ARB_PREEMPT_EN
    hold_d  = hold_q;
    // Counter saturates, so a lone owner is revoked the first cycle anyone else asks.
    preempt = (hold_q >= HW'(MAX_HOLD - 1)) && |(req & ~gnt_q);
`endif
    case (state_q)
      IDLE: take = ena && pick_valid;
      GRANT: begin
`ifdef UIO_ARB_PREEMPT_EN
        if (hold_q != HW'(MAX_HOLD)) hold_d = hold_q + 1'b1;
        if (!req[owner_q] || preempt) begin
`else
        if (!req[owner_q]) begin
`endif
          state_d = TURN;
          gnt_d   = '0;
          turn_d  = '0;
        end
      end
      TURN: begin
        if (turn_q == TW'(TURN_CYCLES - 1)) begin
          take    = ena && pick_valid;
          state_d = IDLE;
        end else begin
          turn_d = turn_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      state_d         = GRANT;
      gnt_d           = '0;
      gnt_d[pick_idx] = 1'b1;
      owner_d         = pick_idx;
`ifdef UIO_ARB_PREEMPT_EN
      hold_d          = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= IW'(N_REQ - 1);
      turn_q  <= '0;
`ifdef UIO_ARB_PREEMPT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      turn_q  <= turn_d;
`ifdef UIO_ARB_PREEMPT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  // AND-OR mux off the registered grant; zero whenever nobody owns the bus.
  always_comb begin
    uio_out = '0;
    uio_oe  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) begin
        uio_out = uio_out | wdata_a[i];
        uio_oe  = uio_oe | woe_a[i];
      end
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state_q != IDLE);

endmodule
